// File: rtl/fetch_seq_ctrl_pkg.sv
// Shared definitions for the fetch sequencer: FSM encoding, parameter defaults, alignment helper.
package fetch_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_OUT  = 2'd2,
        ST_KILL = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_seq_ctrl.sv
// Fetch sequencer: owns the PC, issues single outstanding imem requests, buffers one instruction.
// Optional misaligned-fetch trap (if_adel port) enabled by defining FETCH_ALIGN_CHK_EN.
module fetch_seq_ctrl
    import fetch_seq_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] npc_in,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_pca4,
    output logic [31:0] if_instr
`ifdef FETCH_ALIGN_CHK_EN
    ,
    output logic        if_adel
`endif
);

    fetch_state_e state_q, state_n;
    logic [31:0]  pc_q, pc_n;
    logic [31:0]  instr_q, instr_n;
`ifdef FETCH_ALIGN_CHK_EN
    logic         adel_q, adel_n;
`endif

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_n = state_q;
        pc_n    = pc_q;
        instr_n = instr_q;

        case (state_q)
            ST_REQ: begin
                if (flush) begin
                    pc_n    = flush_pc;
                    state_n = imem_gnt ? ST_KILL : ST_REQ;
                end else if (imem_gnt) begin
                    state_n = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    pc_n    = flush_pc;
                    state_n = imem_rvalid ? ST_REQ : ST_KILL;
                end else if (imem_rvalid) begin
                    instr_n = imem_rdata;
                    state_n = ST_OUT;
                end
            end
            ST_OUT: begin
                if (flush) begin
                    pc_n    = flush_pc;
                    state_n = ST_REQ;
                end else if (!stall) begin
                    pc_n    = npc_in;
                    state_n = ST_REQ;
                end
            end
            ST_KILL: begin
                // The killed response must still be drained; a simultaneous flush only retargets pc.
                if (flush) pc_n = flush_pc;
                if (imem_rvalid) state_n = ST_REQ;
            end
            default: state_n = ST_REQ;
        endcase

`ifdef FETCH_ALIGN_CHK_EN
        adel_n = (state_n == ST_OUT) ? adel_q : 1'b0;
        // A misaligned target never reaches memory; it is presented to decode as a trapping NOP.
        if (state_n == ST_REQ && is_misaligned(pc_n)) begin
            state_n = ST_OUT;
            instr_n = NOP_INSTR;
            adel_n  = 1'b1;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
`ifdef FETCH_ALIGN_CHK_EN
            adel_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
            instr_q <= instr_n;
`ifdef FETCH_ALIGN_CHK_EN
            adel_q  <= adel_n;
`endif
        end
    end

    // Request is masked during reset so the first request appears the cycle after release.
    assign imem_req = (state_q == ST_REQ) && !reset;
`ifdef FETCH_ALIGN_CHK_EN
    assign imem_addr = pc_q;
    assign if_adel   = adel_q;
`else
    assign imem_addr = {pc_q[31:2], 2'b00};
`endif
    assign if_valid = (state_q == ST_OUT);
    assign if_pc    = pc_q;
    assign if_pca4  = pc_q + 32'd4;
    assign if_instr = instr_q;

endmodule
